// File: rtl/cp0_exc_ctrl_if.sv
// CP0 exception-control bus: mfc0/mtc0 access, victim context, interrupt lines and the
// resulting exception request back to the pipeline.
interface cp0_exc_ctrl_if;
    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        WE;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] DOut;
    logic [31:0] EPCOut;
    logic        Req;

    // Pipeline side: drives requests, consumes read data and the exception request.
    modport master (
        output A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  DOut, EPCOut, Req
    );

    // CP0 side.
    modport slave (
        input  A1, A2, DIn, WE, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output DOut, EPCOut, Req
    );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception controller: SR/Cause/EPC/PRId registers, interrupt and exception request
// generation, and the NORMAL/IN_HANDLER state carried in SR.EXL.
module cp0_exc_ctrl (
    input logic           clk,
    input logic           reset,
    cp0_exc_ctrl_if.slave bus
);
    localparam logic [4:0]  RegSr     = 5'd12;
    localparam logic [4:0]  RegCause  = 5'd13;
    localparam logic [4:0]  RegEpc    = 5'd14;
    localparam logic [4:0]  RegPrid   = 5'd15;
    localparam logic [31:0] PridValue = 32'h2022_1106;

    // Handler state doubles as SR.EXL.
    typedef enum logic [0:0] {StNormal, StInHandler} state_e;

    state_e      state_q;
    logic [5:0]  im_q;
    logic        ie_q;
    logic        bd_q;
    logic [5:0]  ip_q;
    logic [4:0]  exc_code_q;
    logic [31:2] epc_q;

    logic        exl;
    logic        int_req;
    logic        exc_req;
    logic        req;
    logic [31:0] victim_pc;
    logic [31:0] sr_val;
    logic [31:0] cause_val;
    logic [31:0] epc_val;
    logic [1:0]  unused_victim_lsb;

    // Request generation and architectural register views.
    always_comb begin
        exl       = (state_q == StInHandler);
        int_req   = (|(bus.HWInt & im_q)) & ie_q & ~exl;
        exc_req   = (bus.ExcCodeIn != 5'd0) & ~exl;
        req       = (int_req | exc_req) & ~reset;
        // Delay-slot victims restart at the branch; wrap-around is intended.
        victim_pc = bus.BDIn ? (bus.VPC - 32'd4) : bus.VPC;
        sr_val    = {16'h0000, im_q, 8'h00, exl, ie_q};
        cause_val = {bd_q, 15'h0000, ip_q, 3'b000, exc_code_q, 2'b00};
        epc_val   = {epc_q, 2'b00};
    end

    assign unused_victim_lsb = victim_pc[1:0];

    // mfc0 read mux; reads see pre-edge contents.
    always_comb begin
        bus.DOut = 32'h0000_0000;
        unique case (bus.A1)
            RegSr:    bus.DOut = sr_val;
            RegCause: bus.DOut = cause_val;
            RegEpc:   bus.DOut = epc_val;
            RegPrid:  bus.DOut = PridValue;
            default:  bus.DOut = 32'h0000_0000;
        endcase
    end

    assign bus.EPCOut = epc_val;
    assign bus.Req    = req;

    // Register and handler-state update; priority is reset > Req > EXLClr > mtc0.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StNormal;
            im_q       <= 6'd0;
            ie_q       <= 1'b0;
            bd_q       <= 1'b0;
            ip_q       <= 6'd0;
            exc_code_q <= 5'd0;
            epc_q      <= 30'd0;
        end else begin
            ip_q <= bus.HWInt;
            if (req) begin
                // Exception entry: any coinciding mtc0 is dropped.
                state_q    <= StInHandler;
                bd_q       <= bus.BDIn;
                exc_code_q <= int_req ? 5'd0 : bus.ExcCodeIn;
                epc_q      <= victim_pc[31:2];
            end else begin
                if (bus.WE && (bus.A2 == RegSr)) begin
                    im_q    <= bus.DIn[15:10];
                    ie_q    <= bus.DIn[0];
                    state_q <= bus.DIn[1] ? StInHandler : StNormal;
                end
                if (bus.WE && (bus.A2 == RegEpc)) begin
                    epc_q <= bus.DIn[31:2];
                end
                // eret overrides an EXL value written by a simultaneous mtc0.
                if (bus.EXLClr) begin
                    state_q <= StNormal;
                end
            end
        end
    end
endmodule
